// File: rtl/fsm_pkg.sv
// -----------------------------------------------------------------------------
// fsm_pkg
//
// Shared definitions for the card/coin FSM front end.
//   - DB_* : 2-bit encodings of the per-channel debounce state machine.
//            Bit 1 of the encoding equals the debounced level.
//   - CH_* : bit positions of the conditioned inputs (C1, C2, I).
// -----------------------------------------------------------------------------
package fsm_pkg;

  // Debounce state encodings.
  localparam logic [1:0] DB_STABLE_LO = 2'b00;
  localparam logic [1:0] DB_ARM_HI    = 2'b01;
  localparam logic [1:0] DB_STABLE_HI = 2'b11;
  localparam logic [1:0] DB_ARM_LO    = 2'b10;

  typedef enum logic [1:0] {
    ST_STABLE_LO = DB_STABLE_LO,
    ST_ARM_HI    = DB_ARM_HI,
    ST_STABLE_HI = DB_STABLE_HI,
    ST_ARM_LO    = DB_ARM_LO
  } db_state_t;

  // Channel index constants for the input vector.
  localparam int CH_C1 = 0;
  localparam int CH_C2 = 1;
  localparam int CH_I  = 2;

  // Debounced level implied by a state: high while stable-high or while a
  // falling edge is still being qualified.
  function automatic logic db_state_level(db_state_t s);
    return (s == ST_STABLE_HI) || (s == ST_ARM_LO);
  endfunction

endpackage : fsm_pkg

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
//
// Single-bit switch conditioner: 2-flop synchronizer, qualification counter
// and a four-state debounce FSM. A new level is accepted only after
// DEBOUNCE_CYCLES consecutive synchronized samples at that level; shorter runs
// are discarded without any output activity.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable samples required (2..65535)
//
// Ports
//   clk            system clock
//   reset          asynchronous, active-high reset
//   raw            unsynchronized switch input
//   level          debounced level (registered)
//   press          one-cycle pulse on an accepted 0->1 transition (registered)
//   release_pulse  one-cycle pulse on an accepted 1->0 transition (registered);
//                  named this way because "release" is a reserved word in
//                  SystemVerilog
// -----------------------------------------------------------------------------
module debounce_channel
  import fsm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press,
  output logic release_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Synchronizer chain; only sync2_q is used downstream.
  logic sync1_q;
  logic sync2_q;

  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  // NOTE: every flop, synchronizer included, gets an async reset so the
  // channel leaves reset in a known STABLE_LO with no pulse pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make sync2_q take the previous
      // sync1_q, giving a true two-stage chain.
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Next-state, counter and pulse logic.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;

    case (state_q)
      ST_STABLE_LO: begin
        if (sync2_q) begin
          state_d = ST_ARM_HI;
          cnt_d   = CNT_ONE;
        end
      end

      ST_ARM_HI: begin
        if (!sync2_q) begin
          state_d = ST_STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // This sample completes the qualifying run.
          state_d = ST_STABLE_HI;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_STABLE_HI: begin
        if (!sync2_q) begin
          state_d = ST_ARM_LO;
          cnt_d   = CNT_ONE;
        end
      end

      ST_ARM_LO: begin
        if (sync2_q) begin
          state_d = ST_STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_STABLE_LO;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_STABLE_LO;
        cnt_d   = '0;
      end
    endcase

    // Level is registered alongside the state it is decoded from.
    level_d = db_state_level(state_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_STABLE_LO;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level         = level_q;
  assign press         = press_q;
  assign release_pulse = release_q;

endmodule : debounce_channel

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//
// Front-end conditioning stage for the card/coin FSM. Each of the N_CH raw
// switch lines (bit 0 = C1, bit 1 = C2, bit 2 = I) is synchronized and
// debounced independently; the outputs are clean registered levels plus
// single-cycle press/release pulses suitable for driving the FSM inputs.
//
// Parameters
//   N_CH             number of independent channels
//   DEBOUNCE_CYCLES  consecutive stable samples required (2..65535)
//
// Ports
//   clk            system clock
//   reset          asynchronous, active-high reset
//   raw            unsynchronized switch inputs
//   level          debounced level per channel
//   press          one-cycle pulse per accepted 0->1 transition
//   release_pulse  one-cycle pulse per accepted 1->0 transition
// -----------------------------------------------------------------------------
module input_conditioner
  import fsm_pkg::*;
#(
  parameter int unsigned N_CH            = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] raw,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_pulse
);

  // Channels share nothing but clock and reset.
  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_channel (
      .clk          (clk),
      .reset        (reset),
      .raw          (raw[ch]),
      .level        (level[ch]),
      .press        (press[ch]),
      .release_pulse(release_pulse[ch])
    );
  end

endmodule : input_conditioner

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
//
// Directed scenarios followed by random switch activity, all compared against
// a run-length reference model: an input change is accepted once the
// synchronized value has disagreed with the current level for DEBOUNCE_CYCLES
// consecutive samples.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

  localparam int N_CH = 3;
  localparam int DB   = 4;

  logic            clk;
  logic            reset;
  logic [N_CH-1:0] raw;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] press;
  logic [N_CH-1:0] release_pulse;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [N_CH-1:0] pipe[$];      // raw values in flight through the synchronizer
  int              run[N_CH];    // consecutive samples disagreeing with level
  logic [N_CH-1:0] lvl_m;
  logic [N_CH-1:0] press_m;
  logic [N_CH-1:0] rel_m;

  // Observed pulse-cycle counts per channel (for pulse-width/count checks).
  int press_seen[N_CH];
  int rel_seen[N_CH];

  input_conditioner #(
    .N_CH           (N_CH),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .raw          (raw),
    .level        (level),
    .press        (press),
    .release_pulse(release_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pipe.delete();
    pipe.push_back('0);
    pipe.push_back('0);
    for (int i = 0; i < N_CH; i++) run[i] = 0;
    lvl_m   = '0;
    press_m = '0;
    rel_m   = '0;
  endtask

  // One clock edge of the model: the sample seen now is raw from two edges ago.
  task automatic model_edge(input logic [N_CH-1:0] r);
    logic [N_CH-1:0] s;
    s = pipe.pop_front();
    pipe.push_back(r);
    press_m = '0;
    rel_m   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (s[i] != lvl_m[i]) begin
        run[i]++;
        if (run[i] == DB) begin
          lvl_m[i] = s[i];
          run[i]   = 0;
          if (s[i]) press_m[i] = 1'b1;
          else      rel_m[i]   = 1'b1;
        end
      end else begin
        run[i] = 0;
      end
    end
  endtask

  task automatic clear_seen();
    for (int i = 0; i < N_CH; i++) begin
      press_seen[i] = 0;
      rel_seen[i]   = 0;
    end
  endtask

  // Advance one clock edge and compare all outputs 1 ns after it.
  task automatic step();
    @(posedge clk);
    model_edge(raw);
    #1;
    check("level", level, lvl_m);
    check("press", press, press_m);
    check("release", release_pulse, rel_m);
    check("press_and_release_overlap", press & release_pulse, '0);
    for (int i = 0; i < N_CH; i++) begin
      press_seen[i] += int'(press[i]);
      rel_seen[i]   += int'(release_pulse[i]);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Assert reset away from any edge, confirm outputs clear at once, hold it
  // across one edge, then release it just after the next edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("reset_level", level, '0);
    check("reset_press", press, '0);
    check("reset_release", release_pulse, '0);
    @(posedge clk);
    #1;
    check("reset_hold_press", press, '0);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [N_CH-1:0] m;
    reset = 1'b0;
    raw   = '0;
    clear_seen();
    model_reset();

    // Power-on reset.
    #2 reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("por_level", level, '0);
    check("por_press", press, '0);
    check("por_release", release_pulse, '0);
    reset = 1'b0;
    steps(3);

    // Clean press on C1: accepted on the 6th edge after raw first sampled high.
    raw = 3'b001;
    steps(5);
    check("clean_press_pre_level", level, 3'b000);
    step();
    check("clean_press_level", level, 3'b001);
    check("clean_press_pulse", press, 3'b001);
    step();
    check("clean_press_pulse_end", press, 3'b000);
    check("clean_press_hold", level, 3'b001);

    // Bounce on C2: 2-cycle runs never qualify.
    clear_seen();
    raw[1] = 1'b1; steps(2);
    raw[1] = 1'b0; steps(2);
    raw[1] = 1'b1; steps(2);
    raw[1] = 1'b0; steps(10);
    check("bounce_level", level[1], 1'b0);
    check("bounce_press_count", press_seen[1], 0);
    check("bounce_release_count", rel_seen[1], 0);

    // Threshold on I: a 4-cycle pulse is accepted, a 3-cycle pulse is not.
    clear_seen();
    raw[2] = 1'b1; steps(DB);
    raw[2] = 1'b0; steps(10);
    check("thresh_accept_press_cycles", press_seen[2], 1);
    check("thresh_accept_release_cycles", rel_seen[2], 1);
    clear_seen();
    raw[2] = 1'b1; steps(DB - 1);
    raw[2] = 1'b0; steps(10);
    check("thresh_reject_press_cycles", press_seen[2], 0);
    check("thresh_reject_release_cycles", rel_seen[2], 0);
    check("thresh_reject_level", level[2], 1'b0);

    // Release on C1.
    raw[0] = 1'b0;
    steps(5);
    check("release_pre_level", level, 3'b001);
    step();
    check("release_level", level, 3'b000);
    check("release_pulse", release_pulse, 3'b001);
    step();
    check("release_pulse_end", release_pulse, 3'b000);

    // Reset mid-count, then a press 6 edges after reset release.
    raw[0] = 1'b1;
    steps(3);
    do_reset();
    steps(5);
    check("post_reset_no_early_press", press, 3'b000);
    step();
    check("post_reset_press", press, 3'b001);
    raw = '0;
    steps(10);

    // Simultaneous press on all channels.
    raw = 3'b111;
    steps(5);
    step();
    check("simul_press", press, 3'b111);
    step();
    check("simul_press_end", press, 3'b000);
    check("simul_level", level, 3'b111);

    // Reset while all levels are high clears them immediately.
    do_reset();
    steps(8);
    check("simul_relevel", level, 3'b111);
    raw = '0;
    steps(10);
    check("idle_level", level, 3'b000);

    // Random activity: each line flips with probability 1/6 per cycle,
    // yielding a mix of glitches and accepted changes.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < N_CH; i++) m[i] = ($urandom_range(5) == 0);
      raw = raw ^ m;
      step();
      if (n == 700) do_reset();
    end
    raw = '0;
    steps(12);
    check("final_level", level, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_input_conditioner
